// File: rtl/tx_pkg.sv
// Shared types and defaults for the transmit bit-timing path.
package tx_pkg;

    // Two-state controller: waiting for a frame request, or pacing a frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } tx_timer_state_t;

    // Default frame shape: start bit + 8 data bits + stop bit, 10 clocks each.
    localparam int TX_BIT_PERIOD = 10;
    localparam int TX_NUM_BITS   = 10;

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 1..rollover_val while enabled and wraps
// back to 1. rollover_flag is high in every cycle the count sits at
// rollover_val. A clear issued together with count_enable restarts the
// sequence at 1, so a new period can begin on the same edge as the clear.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Next count: clear has priority, otherwise advance and wrap to 1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = count_enable ? ONE : '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? ONE : count_q + ONE;
        end
    end

    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/tx_bit_timer.sv
// Transmit bit-timing controller. On an accepted start it pulses load_strobe,
// then pulses shift_strobe at every internal bit boundary, then pulses done
// after the last bit. Frame geometry is captured at start and held for the
// whole frame; abort cancels the frame silently.
module tx_bit_timer
    import tx_pkg::*;
#(
    parameter int CNT_BITS = 4,
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_BITS-1:0] bit_period,
    input  logic [IDX_BITS-1:0] num_bits,
    output logic                busy,
    output logic                load_strobe,
    output logic                shift_strobe,
    output logic [IDX_BITS-1:0] bit_index,
    output logic                done
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

    tx_timer_state_t     state_q, state_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic [IDX_BITS-1:0] nbits_q, nbits_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                load_q, load_d;
    logic                shift_q, shift_d;
    logic                done_q, done_d;

    logic start_acc;
    logic abort_act;
    logic cnt_clear;
    logic cnt_en;
    logic end_of_bit;

    // Abort beats start in IDLE; in ACTIVE, start is simply not looked at.
    assign start_acc = (state_q == IDLE) && start && !abort;
    assign abort_act = (state_q == ACTIVE) && abort;

    // The clock counter restarts on every frame start and on abort, and
    // runs whenever the next cycle is part of a frame, so the first cycle
    // of bit 0 already reads count 1.
    assign cnt_clear = start_acc || abort_act;
    assign cnt_en    = (state_d == ACTIVE);

    flex_counter #(
        .NUM_CNT_BITS(CNT_BITS)
    ) u_bit_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (period_q),
        .rollover_flag(end_of_bit)
    );

    // State, latched frame geometry, bit index and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            nbits_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            nbits_q  <= nbits_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        nbits_d  = nbits_q;
        idx_d    = idx_q;
        load_d   = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d  = ACTIVE;
                    // A zero period or bit count would never end a frame;
                    // treat it as one.
                    period_d = (bit_period == '0) ? CNT_ONE : bit_period;
                    nbits_d  = (num_bits == '0) ? IDX_ONE : num_bits;
                    idx_d    = '0;
                    load_d   = 1'b1;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (end_of_bit) begin
                    if (idx_q == nbits_q - IDX_ONE) begin
                        // Last bit: no shift, the index keeps its final value.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ACTIVE);
    end

    assign busy         = busy_q;
    assign load_strobe  = load_q;
    assign shift_strobe = shift_q;
    assign bit_index    = idx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tx_bit_timer.sv
// Bench for tx_bit_timer: directed scenarios plus random traffic, every
// output checked each cycle against a frame-offset arithmetic model.
module tb_tx_bit_timer;
    import tx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       abort;
    logic [3:0] bit_period;
    logic [3:0] num_bits;
    logic       busy;
    logic       load_strobe;
    logic       shift_strobe;
    logic [3:0] bit_index;
    logic       done;

    always #5 clk = ~clk;

    tx_bit_timer #(
        .CNT_BITS(4),
        .IDX_BITS(4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .bit_period  (bit_period),
        .num_bits    (num_bits),
        .busy        (busy),
        .load_strobe (load_strobe),
        .shift_strobe(shift_strobe),
        .bit_index   (bit_index),
        .done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is described by the cycle whose edge accepted
    // it (m_fs) and its geometry; every output follows from the offset.
    int cur        = 0;
    bit m_have     = 1'b0;
    int m_fs       = 0;
    int m_bp       = 1;
    int m_nb       = 1;
    int m_idle_idx = 0;
    int obs_shift  = 0;
    int obs_busy   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cur);
        end
    endtask

    task automatic model_reset();
        m_have     = 1'b0;
        m_idle_idx = 0;
    endtask

    // Applied at the edge ending cycle cur, with the inputs of cycle cur.
    task automatic model_edge();
        int off;
        int tot;
        bit act;
        if (!n_rst) return;
        off = cur - m_fs - 1;
        tot = m_bp * m_nb;
        act = m_have && (off < tot);
        if (act) begin
            if (abort) begin
                m_have     = 1'b0;
                m_idle_idx = 0;
            end
        end else if (start && !abort) begin
            m_have = 1'b1;
            m_fs   = cur;
            m_bp   = (bit_period == 4'd0) ? 1 : int'(bit_period);
            m_nb   = (num_bits == 4'd0) ? 1 : int'(num_bits);
        end
    endtask

    task automatic check_outputs();
        int off;
        int tot;
        bit e_busy;
        bit e_load;
        bit e_shift;
        bit e_done;
        int e_idx;
        e_busy  = 1'b0;
        e_load  = 1'b0;
        e_shift = 1'b0;
        e_done  = 1'b0;
        e_idx   = m_idle_idx;
        if (m_have) begin
            off = cur - m_fs - 1;
            tot = m_bp * m_nb;
            if (off < tot) begin
                e_busy  = 1'b1;
                e_load  = (off == 0);
                e_shift = (off > 0) && (off % m_bp == 0);
                e_idx   = off / m_bp;
            end else begin
                e_done = (off == tot);
                e_idx  = m_nb - 1;
            end
        end
        chk("busy", busy, e_busy);
        chk("load_strobe", load_strobe, e_load);
        chk("shift_strobe", shift_strobe, e_shift);
        chk("done", done, e_done);
        chk("bit_index", bit_index, e_idx);
        obs_shift += int'(shift_strobe);
        obs_busy  += int'(busy);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // check the following cycle's outputs at the falling edge.
    task automatic step(input logic s, input logic a, input logic [3:0] bp, input logic [3:0] nb);
        start      = s;
        abort      = a;
        bit_period = bp;
        num_bits   = nb;
        @(posedge clk);
        model_edge();
        cur++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [3:0] bp, input logic [3:0] nb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, bp, nb);
    endtask

    initial begin
        n_rst      = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        bit_period = 4'd4;
        num_bits   = 4'd3;
        model_reset();

        // Reset held with start asserted: everything stays quiet.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'd4, 4'd3);
        chk("rst_busy", busy, 0);
        chk("rst_load", load_strobe, 0);
        chk("rst_idx", bit_index, 0);
        n_rst = 1'b1;
        idle(3, 4'd4, 4'd3);
        chk("post_rst_busy", busy, 0);

        // Nominal frame 4 x 3.
        obs_shift = 0;
        obs_busy  = 0;
        step(1'b1, 1'b0, 4'd4, 4'd3);
        chk("nom_load", load_strobe, 1);
        idle(14, 4'd4, 4'd3);
        chk("nom_shifts", obs_shift, 2);
        chk("nom_busy_cycles", obs_busy, 12);

        // Back-to-back frames; start while busy is ignored.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        for (int r = 1; r <= 30; r++) begin
            step((r == 7) || (r == 13), 1'b0, 4'd4, 4'd3);
            if (r == 12) chk("b2b_done", done, 1);
            if (r == 13) chk("b2b_load", load_strobe, 1);
        end
        idle(5, 4'd4, 4'd3);

        // Abort in cycle 6 of a nominal frame.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        for (int r = 1; r <= 15; r++) begin
            step(1'b0, (r == 6), 4'd4, 4'd3);
            if (r == 6) begin
                chk("abort_busy", busy, 0);
                chk("abort_idx", bit_index, 0);
            end
        end

        // Zero period and zero bit count behave as 1/1.
        step(1'b1, 1'b0, 4'd0, 4'd0);
        chk("zero_load", load_strobe, 1);
        step(1'b0, 1'b0, 4'd0, 4'd0);
        chk("zero_done", done, 1);
        idle(3, 4'd0, 4'd0);

        // Largest frame: 15 x 15.
        obs_shift = 0;
        obs_busy  = 0;
        step(1'b1, 1'b0, 4'd15, 4'd15);
        idle(230, 4'd15, 4'd15);
        chk("max_busy_cycles", obs_busy, 225);
        chk("max_shifts", obs_shift, 14);

        // Geometry change mid-frame has no effect.
        obs_shift = 0;
        obs_busy  = 0;
        step(1'b1, 1'b0, 4'd4, 4'd3);
        for (int r = 1; r <= 14; r++) step(1'b0, 1'b0, (r >= 3) ? 4'd7 : 4'd4, 4'd3);
        chk("chg_busy_cycles", obs_busy, 12);

        // Start together with abort in IDLE: no frame.
        step(1'b1, 1'b1, 4'd4, 4'd3);
        chk("start_abort_busy", busy, 0);
        idle(4, 4'd4, 4'd3);

        // Asynchronous reset in the middle of a frame.
        step(1'b1, 1'b0, 4'd5, 4'd4);
        idle(7, 4'd5, 4'd4);
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_busy", busy, 0);
        chk("async_rst_idx", bit_index, 0);
        chk("async_rst_shift", shift_strobe, 0);
        idle(2, 4'd5, 4'd4);
        n_rst = 1'b1;
        idle(25, 4'd5, 4'd4);

        // Default frame geometry from the package.
        step(1'b1, 1'b0, 4'(TX_BIT_PERIOD), 4'(TX_NUM_BITS));
        idle(TX_BIT_PERIOD * TX_NUM_BITS + 3, 4'(TX_BIT_PERIOD), 4'(TX_NUM_BITS));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       rs;
            logic       ra;
            logic [3:0] rbp;
            logic [3:0] rnb;
            rs  = ($urandom_range(0, 3) == 0);
            ra  = ($urandom_range(0, 39) == 0);
            rbp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            rnb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            step(rs, ra, rbp, rnb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_bit_timer.md
Name: tx_bit_timer

Overview:
Bit-timing controller for the serial transmit path. It complements the receive-side timer: instead of sampling incoming bits, it paces outgoing bits. On a start request it emits one load strobe so the transmit shift register captures the frame, then one shift strobe at each bit boundary, then a done pulse. It sits between the transmit control FSM and the parallel-to-serial shift register.

Parameters:
CNT_BITS, 4, width of the clocks-per-bit counter and of bit_period.
IDX_BITS, 4, width of the bit-index counter and of num_bits.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  frame request, sampled only in IDLE.
abort  input  1  synchronous frame cancel, highest priority.
bit_period  input  CNT_BITS  clocks per bit, latched at frame start.
num_bits  input  IDX_BITS  bits per frame, latched at frame start.
busy  output  1  frame in progress.
load_strobe  output  1  one-cycle pulse: shift register loads the frame.
shift_strobe  output  1  one-cycle pulse: shift register advances one bit.
bit_index  output  IDX_BITS  index of the bit currently on the line, 0-based.
done  output  1  one-cycle pulse: frame complete.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on n_rst.
- All outputs are registered.
- Reset values: busy=0, load_strobe=0, shift_strobe=0, done=0, bit_index=0, state=IDLE, internal counters=0. Reset mid-frame returns the block to IDLE immediately, with no done pulse.
- FSM states:
  - IDLE -> ACTIVE on start & !abort.
  - ACTIVE -> IDLE on end of the last bit, or on abort.
- Frame start, with start sampled at edge k:
  - bit_period and num_bits are latched at edge k.
  - Zero values are treated as 1.
  - In cycle k+1: busy=1, load_strobe=1, bit_index=0, clock counter=1.
- In ACTIVE, the clock counter runs 1..bit_period, then wraps to 1.
  - Each bit lasts exactly bit_period cycles.
  - Bit 0 occupies cycles k+1 .. k+bit_period.
- End of bit i, where i < num_bits-1: in the next cycle, shift_strobe=1 for exactly one cycle and bit_index=i+1.
- End of the last bit:
  - Next cycle: state=IDLE, busy=0, done=1 for one cycle.
  - No shift_strobe is issued for the last bit.
  - bit_index holds its final value until the next frame start.
- Total busy time is num_bits*bit_period cycles.
- start while ACTIVE is ignored; there is no queueing.
- start in the done cycle is accepted, because the block is in IDLE. This gives back-to-back frames with zero gap cycles.
- Changes to bit_period or num_bits mid-frame have no effect.
- abort:
  - In ACTIVE: at the next edge, state=IDLE, busy=0, all strobes 0, no done. bit_index resets to 0.
  - Asserted together with start in IDLE: abort wins and no frame starts.
- load_strobe, shift_strobe and done are mutually exclusive in every cycle.

Decomposition:
- Shared package tx_pkg holds:
  - typedef enum logic {IDLE, ACTIVE} tx_timer_state_t.
  - Default constants TX_BIT_PERIOD=10 and TX_NUM_BITS=10 (start + 8 data + stop).
- Sub-module: instantiate the existing flex_counter library block as the clock-per-bit counter.
  - NUM_CNT_BITS=CNT_BITS.
  - rollover_val = latched bit_period.
  - count_enable = ACTIVE.
  - clear = frame start or abort.
  - Its rollover_flag marks end-of-bit.
- The bit-index counter and the FSM stay local to this block.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles with start=1 -> all outputs 0. Release -> still IDLE until start is sampled.
- Nominal frame: bit_period=4, num_bits=3, start sampled at edge 0 ->
  - load_strobe in cycle 1.
  - shift_strobe in cycles 5 and 9, with bit_index 1 and 2.
  - done in cycle 13.
  - busy=1 in cycles 1-12.
- Back-to-back: with the nominal settings, assert start in the done cycle (13) -> load_strobe in cycle 14, no idle gap. Pulse start in cycle 7 (while busy) -> ignored.
- Abort: in the nominal frame, assert abort in cycle 6 -> cycle 7 has busy=0 and bit_index=0. No shift_strobe or done follows.
- Boundary values:
  - bit_period=0, num_bits=0 -> treated as 1/1: load_strobe in cycle 1, done in cycle 2.
  - bit_period=15, num_bits=15 -> busy for 225 cycles with 14 shift_strobes.
- Mid-frame change and simultaneous inputs:
  - Change bit_period from 4 to 7 during the nominal frame -> timing unchanged.
  - Assert start and abort together in IDLE -> no frame.
